// File: rtl/sha256_iter.sv
// ============================================================================
// sha256_iter : iterative SHA-256 compression, one round per clock, chained H
// Revision 1.0
// ============================================================================
`default_nettype none

module sha256_iter (
   input  logic         clk,
   input  logic         reset,
   input  logic         block_valid,
   output logic         block_ready,
   input  logic [511:0] block,
   input  logic         first,
   input  logic         last,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [255:0] digest
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROUND  = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   state_t        state;
   logic [5:0]    t;
   logic          last_q;
   logic [31:0]   w  [0:15];
   logic [31:0]   hv [0:7];
   logic [31:0]   wk [0:7];
   logic [255:0]  digest_q;

   logic [31:0]   t1;
   logic [31:0]   t2;
   logic [31:0]   w_new;
   logic [31:0]   h_sum [0:7];

   // wk[0..7] are the working variables a..h
   always_comb begin
      t1 = wk[7] + big_sigma1(wk[4]) + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6]))
         + K[t] + w[0];
      t2 = big_sigma0(wk[0]) + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
      w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
      for (int i = 0; i < 8; i++) begin
         h_sum[i] = hv[i] + wk[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         t        <= 6'd0;
         last_q   <= 1'b0;
         digest_q <= 256'd0;
         for (int i = 0; i < 8; i++) begin
            hv[i] <= IV[255-32*i -: 32];
         end
      end else begin
         case (state)
            IDLE: begin
               if (block_valid) begin
                  for (int i = 0; i < 16; i++) begin
                     w[i] <= block[511-32*i -: 32];
                  end
                  for (int i = 0; i < 8; i++) begin
                     if (first) begin
                        hv[i] <= IV[255-32*i -: 32];
                        wk[i] <= IV[255-32*i -: 32];
                     end else begin
                        wk[i] <= hv[i];
                     end
                  end
                  last_q <= last;
                  t      <= 6'd0;
                  state  <= ROUND;
               end
            end
            ROUND: begin
               for (int i = 0; i < 15; i++) begin
                  w[i] <= w[i+1];
               end
               w[15] <= w_new;
               wk[0] <= t1 + t2;
               wk[1] <= wk[0];
               wk[2] <= wk[1];
               wk[3] <= wk[2];
               wk[4] <= wk[3] + t1;
               wk[5] <= wk[4];
               wk[6] <= wk[5];
               wk[7] <= wk[6];
               t     <= t + 6'd1;
               if (t == 6'd63) begin
                  state <= UPDATE;
               end
            end
            UPDATE: begin
               for (int i = 0; i < 8; i++) begin
                  hv[i] <= h_sum[i];
               end
               if (last_q) begin
                  digest_q <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                               h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
                  state    <= DONE;
               end else begin
                  state <= IDLE;
               end
            end
            DONE: begin
               if (digest_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign block_ready  = (state == IDLE);
   assign digest_valid = (state == DONE);
   assign digest       = digest_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_iter.sv
// ============================================================================
// tb_sha256_iter : directed-vector self-checking bench for sha256_iter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sha256_iter;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         block_valid = 1'b0;
   logic         block_ready;
   logic [511:0] block = '0;
   logic         first = 1'b0;
   logic         last = 1'b0;
   logic         digest_valid;
   logic         digest_ready = 1'b0;
   logic [255:0] digest;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] BLK_TWO2  = {448'h0, 64'h00000000_000001c0};

   localparam logic [255:0] DIG_ABC   =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_TWO   =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   sha256_iter dut (
      .clk          (clk),
      .reset        (reset),
      .block_valid  (block_valid),
      .block_ready  (block_ready),
      .block        (block),
      .first        (first),
      .last         (last),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .digest       (digest)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a block and returns just after its accept edge (E0 + 1).
   task automatic present(input logic [511:0] blk, input logic f, input logic l);
      block       = blk;
      first       = f;
      last        = l;
      block_valid = 1'b1;
      for (int i = 0; i < 300 && !block_ready; i++) step();
      step();
      block_valid = 1'b0;
   endtask

   task automatic wait_digest(output int n);
      n = 0;
      while (n < 200 && !digest_valid) begin
         step();
         n++;
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (n < 200 && !block_ready) begin
         step();
         n++;
      end
   endtask

   task automatic take_digest();
      digest_ready = 1'b1;
      step();
      digest_ready = 1'b0;
   endtask

   initial begin
      int n;
      logic [255:0] held;
      int bad;

      step();
      step();
      reset = 1'b0;
      check("rst_ready", {255'd0, block_ready}, 256'd1);
      check("rst_dvalid", {255'd0, digest_valid}, 256'd0);
      check("rst_digest", digest, 256'd0);

      // "abc", single block
      present(BLK_ABC, 1'b1, 1'b1);
      check("abc_busy", {255'd0, block_ready}, 256'd0);
      wait_digest(n);
      check("abc_latency", 256'(n), 256'd65);
      check("abc_digest", digest, DIG_ABC);
      take_digest();
      check("abc_idle", {255'd0, block_ready}, 256'd1);
      check("abc_dvalid_low", {255'd0, digest_valid}, 256'd0);

      // empty message
      present(BLK_EMPTY, 1'b1, 1'b1);
      wait_digest(n);
      check("empty_latency", 256'(n), 256'd65);
      check("empty_digest", digest, DIG_EMPTY);
      take_digest();

      // two-block message with block_valid held high across both blocks
      block       = BLK_TWO1;
      first       = 1'b1;
      last        = 1'b0;
      block_valid = 1'b1;
      step();
      block = BLK_TWO2;
      first = 1'b0;
      last  = 1'b1;
      check("two_busy", {255'd0, block_ready}, 256'd0);
      wait_ready(n);
      check("two_ready_latency", 256'(n), 256'd65);
      check("two_no_dvalid", {255'd0, digest_valid}, 256'd0);
      step();
      block_valid = 1'b0;
      check("two_blk2_accepted", {255'd0, block_ready}, 256'd0);
      wait_digest(n);
      check("two_latency", 256'(n), 256'd65);
      check("two_digest", digest, DIG_TWO);

      // backpressure on the pending digest
      held = digest;
      bad  = 0;
      block = BLK_EMPTY;
      first = 1'b1;
      last  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         block_valid = (i % 2 == 0);
         step();
         if (digest !== held || block_ready !== 1'b0 || digest_valid !== 1'b1) bad++;
      end
      block_valid = 1'b0;
      check("bp_stable_cycles", 256'(bad), 256'd0);
      check("bp_digest", digest, DIG_TWO);
      take_digest();
      check("bp_idle", {255'd0, block_ready}, 256'd1);

      // reset at round t = 30
      present(BLK_ABC, 1'b1, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_ready", {255'd0, block_ready}, 256'd1);
      check("midrst_dvalid", {255'd0, digest_valid}, 256'd0);
      present(BLK_ABC, 1'b0, 1'b1);
      wait_digest(n);
      check("midrst_latency", 256'(n), 256'd65);
      check("midrst_digest", digest, DIG_ABC);
      take_digest();

      // chained state discarded by first = 1
      present(BLK_TWO1, 1'b1, 1'b0);
      wait_ready(n);
      check("restart_ready_latency", 256'(n), 256'd65);
      present(BLK_ABC, 1'b1, 1'b1);
      wait_digest(n);
      check("restart_digest", digest, DIG_ABC);
      take_digest();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
